// File: rtl/dmem_lsu.sv
// Load/store unit driving port B of the 1 KB byte-lane BRAM; byte/word loads and stores over valid/ready.
// Optional DMEM_MISALIGN_EN splits misaligned words into two accesses; otherwise they return an error.
module dmem_lsu #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic              i_req_size,
    input  logic              i_req_sext,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [15:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [15:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_b_en,
    output logic              o_b_we_h,
    output logic              o_b_we_l,
    output logic [ADDR_W-2:0] o_b_addr,
    output logic [7:0]        o_b_din_h,
    output logic [7:0]        o_b_din_l,
    input  logic [7:0]        i_b_dout_h,
    input  logic [7:0]        i_b_dout_l
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DMEM_MISALIGN_EN
        ACC2 = 2'd1,
`endif
        RESP = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic we_reg;
    logic size_reg;
    logic sext_reg;
    logic lane_reg;
    logic rsp_err;

`ifdef DMEM_MISALIGN_EN
    localparam logic [ADDR_W-2:0] WORD_ONE = {{(ADDR_W-2){1'b0}}, 1'b1};
    logic [ADDR_W-2:0] addr2_reg;
    logic [7:0]        byte1_reg;
    logic [7:0]        held_h_reg;
`else
    logic err_reg;
`endif

    // Next state and BRAM port drive; everything is forced quiet while reset is asserted.
    always_comb begin
        state_next  = state_reg;
        o_req_ready = 1'b0;
        o_b_en      = 1'b0;
        o_b_we_h    = 1'b0;
        o_b_we_l    = 1'b0;
        o_b_addr    = '0;
        o_b_din_h   = 8'h00;
        o_b_din_l   = 8'h00;
        case (state_reg)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (i_req_size && i_req_addr[0]) begin
`ifdef DMEM_MISALIGN_EN
                        o_b_en     = 1'b1;
                        o_b_addr   = i_req_addr[ADDR_W-1:1];
                        o_b_we_h   = i_req_we;
                        o_b_din_h  = i_req_wdata[7:0];
                        state_next = ACC2;
`else
                        state_next = RESP;
`endif
                    end else if (i_req_size) begin
                        o_b_en     = 1'b1;
                        o_b_addr   = i_req_addr[ADDR_W-1:1];
                        o_b_we_h   = i_req_we;
                        o_b_we_l   = i_req_we;
                        o_b_din_h  = i_req_wdata[15:8];
                        o_b_din_l  = i_req_wdata[7:0];
                        state_next = RESP;
                    end else if (i_req_addr[0]) begin
                        o_b_en     = 1'b1;
                        o_b_addr   = i_req_addr[ADDR_W-1:1];
                        o_b_we_h   = i_req_we;
                        o_b_din_h  = i_req_wdata[7:0];
                        state_next = RESP;
                    end else begin
                        o_b_en     = 1'b1;
                        o_b_addr   = i_req_addr[ADDR_W-1:1];
                        o_b_we_l   = i_req_we;
                        o_b_din_l  = i_req_wdata[7:0];
                        state_next = RESP;
                    end
                end
            end
`ifdef DMEM_MISALIGN_EN
            ACC2: begin
                o_b_en     = 1'b1;
                o_b_addr   = addr2_reg;
                o_b_we_l   = we_reg;
                o_b_din_l  = byte1_reg;
                state_next = RESP;
            end
`endif
            RESP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!i_rst_n) begin
            state_next  = IDLE;
            o_req_ready = 1'b0;
            o_b_en      = 1'b0;
            o_b_we_h    = 1'b0;
            o_b_we_l    = 1'b0;
            o_b_addr    = '0;
            o_b_din_h   = 8'h00;
            o_b_din_l   = 8'h00;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            size_reg   <= 1'b0;
            sext_reg   <= 1'b0;
            lane_reg   <= 1'b0;
`ifdef DMEM_MISALIGN_EN
            addr2_reg  <= '0;
            byte1_reg  <= 8'h00;
            held_h_reg <= 8'h00;
`else
            err_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && i_req_valid) begin
                we_reg    <= i_req_we;
                size_reg  <= i_req_size;
                sext_reg  <= i_req_sext & ~i_req_size;
                lane_reg  <= i_req_addr[0];
`ifdef DMEM_MISALIGN_EN
                // Second half of a split word wraps from the top word back to word 0.
                addr2_reg <= i_req_addr[ADDR_W-1:1] + WORD_ONE;
                byte1_reg <= i_req_wdata[15:8];
`else
                err_reg   <= i_req_size & i_req_addr[0];
`endif
            end
`ifdef DMEM_MISALIGN_EN
            if (state_reg == ACC2) begin
                held_h_reg <= i_b_dout_h;
            end
`endif
        end
    end

`ifdef DMEM_MISALIGN_EN
    assign rsp_err = 1'b0;
`else
    assign rsp_err = err_reg;
`endif

    logic [7:0]  lane_byte;
    logic [15:0] byte_ext;
    logic [15:0] load_data;

    assign lane_byte     = lane_reg ? i_b_dout_h : i_b_dout_l;
    assign byte_ext[7:0] = lane_byte;

    genvar gi;
    generate
        for (gi = 8; gi < 16; gi++) begin : g_ext
            assign byte_ext[gi] = sext_reg & lane_byte[7];
        end
    endgenerate

    // BRAM is idle during RESP, so dout stays valid for the whole response.
    always_comb begin
        load_data = byte_ext;
        if (size_reg) begin
`ifdef DMEM_MISALIGN_EN
            load_data = lane_reg ? {i_b_dout_l, held_h_reg} : {i_b_dout_h, i_b_dout_l};
`else
            load_data = {i_b_dout_h, i_b_dout_l};
`endif
        end
        o_rsp_valid = (state_reg == RESP);
        o_rsp_err   = (state_reg == RESP) & rsp_err;
        o_rsp_rdata = 16'h0000;
        if ((state_reg == RESP) && !we_reg && !rsp_err) begin
            o_rsp_rdata = load_data;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: vector table plus scoreboard against a BRAM model; hand sequences for
// backpressure and reset. Covers both builds depending on DMEM_MISALIGN_EN.
module tb_dmem_lsu;

    localparam int ADDR_W = 10;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic              i_req_we = 1'b0;
    logic              i_req_size = 1'b0;
    logic              i_req_sext = 1'b0;
    logic [ADDR_W-1:0] i_req_addr = '0;
    logic [15:0]       i_req_wdata = 16'h0000;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b0;
    logic [15:0]       o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_b_en;
    logic              o_b_we_h;
    logic              o_b_we_l;
    logic [ADDR_W-2:0] o_b_addr;
    logic [7:0]        o_b_din_h;
    logic [7:0]        o_b_din_l;
    logic [7:0]        i_b_dout_h = 8'h00;
    logic [7:0]        i_b_dout_l = 8'h00;

    always #5 i_clk = ~i_clk;

    dmem_lsu #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_size  (i_req_size),
        .i_req_sext  (i_req_sext),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_b_en      (o_b_en),
        .o_b_we_h    (o_b_we_h),
        .o_b_we_l    (o_b_we_l),
        .o_b_addr    (o_b_addr),
        .o_b_din_h   (o_b_din_h),
        .o_b_din_l   (o_b_din_l),
        .i_b_dout_h  (i_b_dout_h),
        .i_b_dout_l  (i_b_dout_l)
    );

    // Byte-lane BRAM model, read-first, dout holds when not enabled.
    logic [7:0] mem_h [0:511];
    logic [7:0] mem_l [0:511];

    always @(posedge i_clk) begin
        if (o_b_en) begin
            i_b_dout_h <= mem_h[o_b_addr];
            i_b_dout_l <= mem_l[o_b_addr];
            if (o_b_we_h) mem_h[o_b_addr] <= o_b_din_h;
            if (o_b_we_l) mem_l[o_b_addr] <= o_b_din_l;
        end
    end

    typedef struct {
        logic        we;
        logic        size;
        logic        sext;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        e0_en;
        logic        e0_we_h;
        logic        e0_we_l;
        logic [8:0]  e0_addr;
        logic [7:0]  e0_din_h;
        logic [7:0]  e0_din_l;
        logic        e1_en;
        logic [8:0]  e1_addr;
        logic [7:0]  e1_din_l;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;
    int txn = 0;

    logic       s0_en, s0_we_h, s0_we_l;
    logic [8:0] s0_addr;
    logic [7:0] s0_din_h, s0_din_l;
    logic       s1_en, s1_we_l;
    logic [8:0] s1_addr;
    logic [7:0] s1_din_l;

    function automatic vec_t mk(
        input logic we, input logic size, input logic sext, input logic [9:0] addr,
        input logic [15:0] wdata, input logic [15:0] rd, input logic err, input int lat,
        input logic en, input logic wh, input logic wl, input logic [8:0] ba,
        input logic [7:0] dh, input logic [7:0] dl,
        input logic e1en, input logic [8:0] ba1, input logic [7:0] dl1);
        vec_t v;
        v.we = we; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat;
        v.e0_en = en; v.e0_we_h = wh; v.e0_we_l = wl; v.e0_addr = ba;
        v.e0_din_h = dh; v.e0_din_l = dl;
        v.e1_en = e1en; v.e1_addr = ba1; v.e1_din_l = dl1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic snap0();
        s0_en = o_b_en; s0_we_h = o_b_we_h; s0_we_l = o_b_we_l;
        s0_addr = o_b_addr; s0_din_h = o_b_din_h; s0_din_l = o_b_din_l;
    endtask

    // Drive one request, wait (bounded) for acceptance, record the accept-cycle BRAM drive.
    task automatic issue(input vec_t v);
        int n;
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = v.we; i_req_size = v.size; i_req_sext = v.sext;
        i_req_addr = v.addr; i_req_wdata = v.wdata;
        sb.push_back(v);
        #1;
        n = 0;
        while (!o_req_ready && n < 20) begin
            @(negedge i_clk); #1; n++;
        end
        chk("req_ready", {31'd0, o_req_ready}, 32'd1);
        snap0();
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    // Pop the expected result and compare once the response shows up.
    task automatic collect();
        vec_t e;
        int lat;
        e = sb.pop_front();
        @(negedge i_clk); #1;
        lat = 1;
        s1_en = o_b_en; s1_we_l = o_b_we_l; s1_addr = o_b_addr; s1_din_l = o_b_din_l;
        while (!o_rsp_valid && lat < 10) begin
            @(negedge i_clk); #1; lat++;
        end
        txn++;
        $display("txn %0d we=%0b size=%0b sext=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
                 txn, e.we, e.size, e.sext, e.addr, e.wdata, o_rsp_rdata, o_rsp_err, lat);
        chk("rsp_latency", lat, e.exp_lat);
        chk("rsp_rdata", {16'd0, o_rsp_rdata}, {16'd0, e.exp_rdata});
        chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.exp_err});
        chk("b_en_first", {31'd0, s0_en}, {31'd0, e.e0_en});
        if (e.e0_en) begin
            chk("b_we_h_first", {31'd0, s0_we_h}, {31'd0, e.e0_we_h});
            chk("b_we_l_first", {31'd0, s0_we_l}, {31'd0, e.e0_we_l});
            chk("b_addr_first", {23'd0, s0_addr}, {23'd0, e.e0_addr});
            if (e.e0_we_h) chk("b_din_h_first", {24'd0, s0_din_h}, {24'd0, e.e0_din_h});
            if (e.e0_we_l) chk("b_din_l_first", {24'd0, s0_din_l}, {24'd0, e.e0_din_l});
        end
        chk("b_en_second", {31'd0, s1_en}, {31'd0, e.e1_en});
        if (e.e1_en) begin
            chk("b_addr_second", {23'd0, s1_addr}, {23'd0, e.e1_addr});
            chk("b_we_l_second", {31'd0, s1_we_l}, {31'd0, e.we});
            if (e.we) chk("b_din_l_second", {24'd0, s1_din_l}, {24'd0, e.e1_din_l});
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        int n;
        for (int i = 0; i < 512; i++) begin
            mem_h[i] = 8'h00;
            mem_l[i] = 8'h00;
        end

        //        we size sext addr    wdata     rdata     err lat en wh wl baddr   dh     dl     e1 baddr1  dl1
        vecs.push_back(mk(1, 1, 0, 10'h010, 16'hBEEF, 16'h0000, 0, 1, 1, 1, 1, 9'h008, 8'hBE, 8'hEF, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 1, 0, 10'h010, 16'h0000, 16'hBEEF, 0, 1, 1, 0, 0, 9'h008, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(1, 1, 0, 10'h010, 16'h807F, 16'h0000, 0, 1, 1, 1, 1, 9'h008, 8'h80, 8'h7F, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 0, 1, 10'h011, 16'h0000, 16'hFF80, 0, 1, 1, 0, 0, 9'h008, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 0, 0, 10'h011, 16'h0000, 16'h0080, 0, 1, 1, 0, 0, 9'h008, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 0, 1, 10'h010, 16'h0000, 16'h007F, 0, 1, 1, 0, 0, 9'h008, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(1, 1, 0, 10'h022, 16'h3344, 16'h0000, 0, 1, 1, 1, 1, 9'h011, 8'h33, 8'h44, 0, 9'h000, 8'h00));
        vecs.push_back(mk(1, 0, 0, 10'h023, 16'h1255, 16'h0000, 0, 1, 1, 1, 0, 9'h011, 8'h55, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 1, 0, 10'h022, 16'h0000, 16'h5544, 0, 1, 1, 0, 0, 9'h011, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(1, 0, 0, 10'h024, 16'h00AB, 16'h0000, 0, 1, 1, 0, 1, 9'h012, 8'h00, 8'hAB, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 0, 1, 10'h024, 16'h0000, 16'hFFAB, 0, 1, 1, 0, 0, 9'h012, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(1, 1, 0, 10'h3FE, 16'h1234, 16'h0000, 0, 1, 1, 1, 1, 9'h1FF, 8'h12, 8'h34, 0, 9'h000, 8'h00));
        vecs.push_back(mk(1, 1, 0, 10'h000, 16'h5678, 16'h0000, 0, 1, 1, 1, 1, 9'h000, 8'h56, 8'h78, 0, 9'h000, 8'h00));
`ifdef DMEM_MISALIGN_EN
        vecs.push_back(mk(1, 1, 0, 10'h3FF, 16'hA1B2, 16'h0000, 0, 2, 1, 1, 0, 9'h1FF, 8'hB2, 8'h00, 1, 9'h000, 8'hA1));
        vecs.push_back(mk(0, 1, 0, 10'h3FF, 16'h0000, 16'hA1B2, 0, 2, 1, 0, 0, 9'h1FF, 8'h00, 8'h00, 1, 9'h000, 8'h00));
        vecs.push_back(mk(0, 1, 0, 10'h3FE, 16'h0000, 16'hB234, 0, 1, 1, 0, 0, 9'h1FF, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 1, 0, 10'h000, 16'h0000, 16'h56A1, 0, 1, 1, 0, 0, 9'h000, 8'h00, 8'h00, 0, 9'h000, 8'h00));
`else
        vecs.push_back(mk(0, 1, 0, 10'h005, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 9'h000, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(1, 1, 0, 10'h3FF, 16'hA1B2, 16'h0000, 1, 1, 0, 0, 0, 9'h000, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 1, 0, 10'h3FE, 16'h0000, 16'h1234, 0, 1, 1, 0, 0, 9'h1FF, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        vecs.push_back(mk(0, 1, 0, 10'h000, 16'h0000, 16'h5678, 0, 1, 1, 0, 0, 9'h000, 8'h00, 8'h00, 0, 9'h000, 8'h00));
`endif

        // Reset state, with a request already pending.
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 1'b1; i_req_addr = 10'h010;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); #1;
        chk("reset_req_ready", {31'd0, o_req_ready}, 32'd0);
        chk("reset_b_en", {31'd0, o_b_en}, 32'd0);
        chk("reset_b_we", {30'd0, o_b_we_h, o_b_we_l}, 32'd0);
        chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", {16'd0, o_rsp_rdata}, 32'd0);
        chk("reset_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        i_req_valid = 1'b0;
        i_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i]);
            collect();
        end

        // Backpressure: response held for 5 cycles while a new request waits.
        issue(mk(0, 1, 0, 10'h010, 16'h0000, 16'h807F, 0, 1, 1, 0, 0, 9'h008, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        e = sb.pop_front();
        n = 0;
        @(negedge i_clk); #1;
        while (!o_rsp_valid && n < 10) begin
            @(negedge i_clk); #1; n++;
        end
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 1'b0; i_req_sext = 1'b1; i_req_addr = 10'h011;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", {16'd0, o_rsp_rdata}, {16'd0, e.exp_rdata});
            chk("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
            @(negedge i_clk);
        end
        txn++;
        $display("txn %0d backpressure rdata=%h held 5 cycles", txn, o_rsp_rdata);
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        sb.push_back(mk(0, 0, 1, 10'h011, 16'h0000, 16'hFF80, 0, 1, 1, 0, 0, 9'h008, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        @(negedge i_clk); #1;
        chk("bp_req_ready_after", {31'd0, o_req_ready}, 32'd1);
        snap0();
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        collect();

        // Reset during RESP.
        issue(mk(0, 1, 0, 10'h022, 16'h0000, 16'h5544, 0, 1, 1, 0, 0, 9'h011, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        e = sb.pop_front();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("rst_resp_req_ready", {31'd0, o_req_ready}, 32'd0);
        chk("rst_resp_b_en", {31'd0, o_b_en}, 32'd0);
        @(negedge i_clk); #1;
        chk("rst_resp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_resp_rdata", {16'd0, o_rsp_rdata}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;
        chk("rst_resp_idle", {31'd0, o_req_ready}, 32'd1);
        txn++;
        $display("txn %0d reset in RESP, dropped response for addr %h", txn, e.addr);

`ifdef DMEM_MISALIGN_EN
        // Reset during the second half of a split store: only the first half may land.
        issue(mk(1, 1, 0, 10'h101, 16'hCCDD, 16'h0000, 0, 2, 1, 1, 0, 9'h080, 8'hDD, 8'h00, 1, 9'h081, 8'hCC));
        e = sb.pop_front();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("rst_acc2_b_en", {31'd0, o_b_en}, 32'd0);
        chk("rst_acc2_we_l", {31'd0, o_b_we_l}, 32'd0);
        chk("rst_acc2_req_ready", {31'd0, o_req_ready}, 32'd0);
        @(negedge i_clk); #1;
        chk("rst_acc2_valid", {31'd0, o_rsp_valid}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;
        chk("rst_acc2_idle", {31'd0, o_req_ready}, 32'd1);
        txn++;
        $display("txn %0d reset in ACC2 for split store at %h", txn, e.addr);
        issue(mk(0, 0, 0, 10'h101, 16'h0000, 16'h00DD, 0, 1, 1, 0, 0, 9'h080, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        collect();
        issue(mk(0, 1, 0, 10'h102, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, 9'h081, 8'h00, 8'h00, 0, 9'h000, 8'h00));
        collect();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
